// File: rtl/log_antilog_if.sv
// Stream handshake bundle for the log_antilog unit: log input on one side,
// linear magnitude output on the other, each with valid/ready.
interface log_antilog_if #(
  parameter int LW = 8,
  parameter int OW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] in_log;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_ovf;

  modport master (
    output in_valid, in_log, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_log, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/log_antilog.sv
// Three-stage Mitchell antilog: 2^(k+f) ~= 2^k * (1+f), signed fixed-point log
// in, unsigned fixed-point magnitude out. Define ANTILOG_SAT_EN to saturate.
module log_antilog #(
  parameter int LW  = 8,
  parameter int FW  = 4,
  parameter int OW  = 16,
  parameter int OFW = 12
) (
  input logic          clk,
  input logic          rst_n,
  log_antilog_if.slave bus
);
  localparam int KW     = LW - FW;
  localparam int STAGES = 3;
  localparam int SOFF   = OFW - FW;
`ifdef ANTILOG_SAT_EN
  // Wide enough for the largest left shift so overflow bits survive to S3.
  localparam int KMAX = (1 << (KW - 1)) - 1;
  localparam int RW0  = FW + 1 + KMAX + SOFF;
  localparam int RW   = (RW0 > OW) ? RW0 : OW + 1;
`else
  // Wrapping build only keeps the low OW bits, so shift directly at that width.
  localparam int RW = OW;
`endif

  logic [STAGES:1]       vld_pipe;
  logic                  adv;
  logic signed [KW-1:0]  k_q;
  logic [FW-1:0]         f_q;
  logic [RW-1:0]         raw_d, raw_q;
  logic [OW-1:0]         data_q;
  int                    shamt;

  assign adv           = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
  end

  // S1: split the log into integer and fraction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
      f_q <= '0;
    end else if (adv && bus.in_valid) begin
      k_q <= bus.in_log[LW-1:FW];
      f_q <= bus.in_log[FW-1:0];
    end
  end

  // S2: mantissa {1,f} barrel-shifted by k plus the fraction realignment
  always_comb begin
    shamt = int'(k_q) + SOFF;
    raw_d = '0;
    if (shamt >= 0)       raw_d = RW'({1'b1, f_q}) << shamt;
    else if (-shamt <= FW) raw_d = RW'({1'b1, f_q}) >> (-shamt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   raw_q <= '0;
    else if (adv && vld_pipe[1])  raw_q <= raw_d;
  end

  // S3: overflow handling and output register
`ifdef ANTILOG_SAT_EN
  logic ovf_w, ovf_q;
  assign ovf_w       = |raw_q[RW-1:OW];
  assign bus.out_ovf = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else if (adv && vld_pipe[2]) begin
      data_q <= ovf_w ? '1 : raw_q[OW-1:0];
      ovf_q  <= ovf_w;
    end
  end
`else
  assign bus.out_ovf = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   data_q <= '0;
    else if (adv && vld_pipe[2])  data_q <= raw_q;
  end
`endif
endmodule
